// File: rtl/cpu_pkg.sv
// Shared types and widths for the MEM pipeline stage.
package cpu_pkg;

  localparam int unsigned WORD_W = 32;
  localparam int unsigned REG_W  = 5;

  typedef enum logic {
    IDLE = 1'b0,
    WAIT = 1'b1
  } state_e;

  // A word access must sit on a 4-byte boundary.
  function automatic logic is_misaligned(input logic [WORD_W-1:0] addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/mem_access_stage_if.sv
// Data-memory request/acknowledge bus between the MEM stage and memory.
interface mem_access_stage_if;

  logic                       memReq;
  logic                       memWe;
  logic [cpu_pkg::WORD_W-1:0] memAddr;
  logic [cpu_pkg::WORD_W-1:0] memWdata;
  logic                       memAck;
  logic [cpu_pkg::WORD_W-1:0] memRdata;

  modport master (
    output memReq, memWe, memAddr, memWdata,
    input  memAck, memRdata
  );

  modport slave (
    input  memReq, memWe, memAddr, memWdata,
    output memAck, memRdata
  );

endinterface

// File: rtl/mem_wb_reg.sv
// MEM/WB pipeline register: full load, bubble insert (RegWrite cleared only),
// with the load-data field updated only when the instruction was a load.
module mem_wb_reg
  import cpu_pkg::*;
(
  input  logic              clk,
  input  logic              rst_n,
  input  logic              load_en,
  input  logic              bubble,
  input  logic              rdata_en,
  input  logic              reg_write_in,
  input  logic              memto_reg_in,
  input  logic [REG_W-1:0]  dest_in,
  input  logic [WORD_W-1:0] alu_in,
  input  logic [WORD_W-1:0] rdata_in,
  output logic              reg_write_out,
  output logic              memto_reg_out,
  output logic [REG_W-1:0]  dest_out,
  output logic [WORD_W-1:0] alu_out,
  output logic [WORD_W-1:0] rdata_out
);

  logic              reg_write_q, reg_write_d;
  logic              memto_reg_q, memto_reg_d;
  logic [REG_W-1:0]  dest_q, dest_d;
  logic [WORD_W-1:0] alu_q, alu_d;
  logic [WORD_W-1:0] rdata_q, rdata_d;

  // Next-state selection: load wins, bubble only kills the register write.
  always_comb begin
    reg_write_d = reg_write_q;
    memto_reg_d = memto_reg_q;
    dest_d      = dest_q;
    alu_d       = alu_q;
    rdata_d     = rdata_q;
    if (load_en) begin
      reg_write_d = reg_write_in;
      memto_reg_d = memto_reg_in;
      dest_d      = dest_in;
      alu_d       = alu_in;
      if (rdata_en) begin
        rdata_d = rdata_in;
      end
    end else if (bubble) begin
      reg_write_d = 1'b0;
    end
  end

  // Pipeline register storage with asynchronous clear.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      reg_write_q <= 1'b0;
      memto_reg_q <= 1'b0;
      dest_q      <= '0;
      alu_q       <= '0;
      rdata_q     <= '0;
    end else begin
      reg_write_q <= reg_write_d;
      memto_reg_q <= memto_reg_d;
      dest_q      <= dest_d;
      alu_q       <= alu_d;
      rdata_q     <= rdata_d;
    end
  end

  assign reg_write_out = reg_write_q;
  assign memto_reg_out = memto_reg_q;
  assign dest_out      = dest_q;
  assign alu_out       = alu_q;
  assign rdata_out     = rdata_q;

endmodule

// File: rtl/mem_access_stage.sv
// MEM pipeline stage: issues data-memory requests, stalls upstream until
// acknowledge or timeout, flags illegal accesses and loads MEM/WB.
module mem_access_stage
  import cpu_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYC = 255
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              validIN,
  input  logic              BranchIN,
  input  logic              MemReadIN,
  input  logic              MemtoRegIN,
  input  logic              MemWriteIN,
  input  logic              RegWriteIN,
  input  logic              zeroIN,
  input  logic [REG_W-1:0]  destinationRegisterIN,
  input  logic [WORD_W-1:0] ALUResultIN,
  input  logic [WORD_W-1:0] readData2IN,
  mem_access_stage_if.master bus,
  output logic              stall,
  output logic              PCSrc,
  output logic              RegWriteOUT,
  output logic              MemtoRegOUT,
  output logic [REG_W-1:0]  destinationRegisterOUT,
  output logic [WORD_W-1:0] ALUResultOUT,
  output logic [WORD_W-1:0] readDataOUT,
  output logic              memError
);

  // Last WAIT cycle index before the request is abandoned.
  localparam logic [7:0] TMO_LAST = 8'(TIMEOUT_CYC - 1);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic [WORD_W-1:0] addr_q, addr_d;
  logic [WORD_W-1:0] wdata_q, wdata_d;
  logic              we_q, we_d;
  logic              err_q, err_d;

  logic is_mem, bad_op;
  logic req, stall_c;
  logic wb_load, wb_bubble, wb_rdata_en;

  assign is_mem = validIN & (MemReadIN | MemWriteIN);
  assign bad_op = is_mem & ((MemReadIN & MemWriteIN) | is_misaligned(ALUResultIN));

  // Request sequencing, timeout counting and MEM/WB load decisions.
  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    we_d        = we_q;
    err_d       = err_q;
    req         = 1'b0;
    stall_c     = 1'b0;
    wb_load     = 1'b0;
    wb_bubble   = 1'b0;
    wb_rdata_en = 1'b0;
    case (state_q)
      IDLE: begin
        if (!validIN) begin
          wb_bubble = 1'b1;
        end else if (!is_mem) begin
          wb_load = 1'b1;
        end else if (bad_op) begin
          wb_bubble = 1'b1;
          err_d     = 1'b1;
        end else begin
          req     = 1'b1;
          addr_d  = ALUResultIN;
          wdata_d = readData2IN;
          we_d    = MemWriteIN;
          if (bus.memAck) begin
            wb_load     = 1'b1;
            wb_rdata_en = MemReadIN;
          end else begin
            stall_c = 1'b1;
            state_d = WAIT;
            cnt_d   = '0;
          end
        end
      end
      WAIT: begin
        // Ack on the final allowed cycle still completes the access.
        req = 1'b1;
        if (bus.memAck) begin
          wb_load     = 1'b1;
          wb_rdata_en = MemReadIN;
          state_d     = IDLE;
        end else if (cnt_q == TMO_LAST) begin
          wb_bubble = 1'b1;
          err_d     = 1'b1;
          state_d   = IDLE;
        end else begin
          stall_c = 1'b1;
          cnt_d   = cnt_q + 8'd1;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  // FSM, timeout counter, registered request copy and sticky error.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      we_q    <= we_d;
      err_q   <= err_d;
    end
  end

  // The IDLE request is combinational from the inputs, so reset gates the
  // bus and stall directly to keep them low while rst_n is asserted.
  assign bus.memReq   = rst_n & req;
  assign bus.memWe    = rst_n & req & ((state_q == IDLE) ? MemWriteIN : we_q);
  assign bus.memAddr  = !rst_n ? '0 :
                        ((state_q == IDLE) && req) ? ALUResultIN : addr_q;
  assign bus.memWdata = !rst_n ? '0 :
                        ((state_q == IDLE) && req) ? readData2IN : wdata_q;

  assign stall    = rst_n & stall_c;
  assign PCSrc    = BranchIN & zeroIN & validIN;
  assign memError = err_q;

  mem_wb_reg u_mem_wb_reg (
    .clk           (clk),
    .rst_n         (rst_n),
    .load_en       (wb_load),
    .bubble        (wb_bubble),
    .rdata_en      (wb_rdata_en),
    .reg_write_in  (RegWriteIN),
    .memto_reg_in  (MemtoRegIN),
    .dest_in       (destinationRegisterIN),
    .alu_in        (ALUResultIN),
    .rdata_in      (bus.memRdata),
    .reg_write_out (RegWriteOUT),
    .memto_reg_out (MemtoRegOUT),
    .dest_out      (destinationRegisterOUT),
    .alu_out       (ALUResultOUT),
    .rdata_out     (readDataOUT)
  );

endmodule

// File: tb/tb_mem_access_stage.sv
// Bench for mem_access_stage: directed cases plus random instructions
// checked against a per-instruction outcome model.
module tb_mem_access_stage;

  localparam int unsigned T = 4;

  logic        clk;
  logic        rst_n;
  logic        validIN, BranchIN, MemReadIN, MemtoRegIN, MemWriteIN, RegWriteIN, zeroIN;
  logic [4:0]  destinationRegisterIN;
  logic [31:0] ALUResultIN, readData2IN;
  logic        stall, PCSrc, RegWriteOUT, MemtoRegOUT, memError;
  logic [4:0]  destinationRegisterOUT;
  logic [31:0] ALUResultOUT, readDataOUT;

  mem_access_stage_if bus ();

  mem_access_stage #(.TIMEOUT_CYC(T)) dut (
    .clk                    (clk),
    .rst_n                  (rst_n),
    .validIN                (validIN),
    .BranchIN               (BranchIN),
    .MemReadIN              (MemReadIN),
    .MemtoRegIN             (MemtoRegIN),
    .MemWriteIN             (MemWriteIN),
    .RegWriteIN             (RegWriteIN),
    .zeroIN                 (zeroIN),
    .destinationRegisterIN  (destinationRegisterIN),
    .ALUResultIN            (ALUResultIN),
    .readData2IN            (readData2IN),
    .bus                    (bus),
    .stall                  (stall),
    .PCSrc                  (PCSrc),
    .RegWriteOUT            (RegWriteOUT),
    .MemtoRegOUT            (MemtoRegOUT),
    .destinationRegisterOUT (destinationRegisterOUT),
    .ALUResultOUT           (ALUResultOUT),
    .readDataOUT            (readDataOUT),
    .memError               (memError)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int n_cmp = 0;
  int n_bad = 0;

  // Expected MEM/WB contents and error flag.
  logic        e_rw, e_mtr, e_err;
  logic [4:0]  e_dst;
  logic [31:0] e_alu, e_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic check_wb();
    chk("RegWriteOUT", RegWriteOUT, e_rw);
    chk("MemtoRegOUT", MemtoRegOUT, e_mtr);
    chk("destOUT", destinationRegisterOUT, e_dst);
    chk("ALUResultOUT", ALUResultOUT, e_alu);
    chk("readDataOUT", readDataOUT, e_rd);
    chk("memError", memError, e_err);
  endtask

  task automatic zero_inputs();
    validIN = 0; BranchIN = 0; MemReadIN = 0; MemtoRegIN = 0; MemWriteIN = 0;
    RegWriteIN = 0; zeroIN = 0; destinationRegisterIN = '0;
    ALUResultIN = '0; readData2IN = '0; bus.memAck = 0; bus.memRdata = '0;
  endtask

  // Assert reset, check everything is cleared at once, release on a negedge.
  task automatic apply_reset();
    rst_n = 1'b0;
    #1;
    e_rw = 0; e_mtr = 0; e_dst = '0; e_alu = '0; e_rd = '0; e_err = 0;
    chk("rst_memReq", bus.memReq, 1'b0);
    chk("rst_memWe", bus.memWe, 1'b0);
    chk("rst_memAddr", bus.memAddr, 32'h0);
    chk("rst_memWdata", bus.memWdata, 32'h0);
    chk("rst_stall", stall, 1'b0);
    check_wb();
    zero_inputs();
    @(negedge clk);
    rst_n = 1'b1;
  endtask

  // One instruction from presentation until the stage lets it go.
  // k = cycle index (0 = first cycle) on which memory acknowledges.
  task automatic run_instr(input logic v, br, zr, mr, mw, mtr, rw,
                           input logic [4:0] dst, input logic [31:0] alu, wd,
                           input int unsigned k, input logic [31:0] rd);
    logic        is_mem, bad, good, acked;
    int unsigned last;
    logic [31:0] rd_seen;
    is_mem  = v && (mr || mw);
    bad     = is_mem && ((mr && mw) || (alu[1:0] != 2'b00));
    good    = is_mem && !bad;
    acked   = good && (k <= T);
    last    = !good ? 0 : (acked ? k : T);
    rd_seen = '0;
    validIN = v; BranchIN = br; zeroIN = zr; MemReadIN = mr; MemWriteIN = mw;
    MemtoRegIN = mtr; RegWriteIN = rw; destinationRegisterIN = dst;
    ALUResultIN = alu; readData2IN = wd;
    for (int unsigned c = 0; c <= last; c++) begin
      bus.memAck   = good ? (c == k) : 1'($urandom_range(0, 1));
      bus.memRdata = (good && c == k) ? rd : $urandom();
      #1;
      chk("stall", stall, good && (c != last));
      chk("memReq", bus.memReq, good);
      if (c == 0) chk("PCSrc", PCSrc, v & br & zr);
      if (good) begin
        chk("memAddr", bus.memAddr, alu);
        chk("memWdata", bus.memWdata, wd);
        chk("memWe", bus.memWe, mw);
      end else begin
        chk("memWe_idle", bus.memWe, 1'b0);
      end
      rd_seen = bus.memRdata;
      @(posedge clk);
      #1;
      if (c == last) begin
        if (!v || bad || (good && !acked)) begin
          e_rw = 1'b0;
          if (v) e_err = 1'b1;
        end else begin
          e_rw = rw; e_mtr = mtr; e_dst = dst; e_alu = alu;
          if (good && mr) e_rd = rd_seen;
        end
      end
      check_wb();
      @(negedge clk);
    end
    bus.memAck = 1'b0;
  endtask

  logic        r_v, r_br, r_zr, r_mr, r_mw;
  logic [31:0] r_alu;
  int unsigned kind;

  initial begin
    rst_n = 1'b1;
    zero_inputs();
    #2;
    apply_reset();

    // ADD r5 = 0x10
    run_instr(1, 0, 0, 0, 0, 0, 1, 5'd5, 32'h10, 32'h0, 0, 32'h0);
    // LW 0x100, ack on 4th WAIT cycle (also the last allowed cycle)
    run_instr(1, 0, 0, 1, 0, 1, 1, 5'd7, 32'h100, 32'h0, 4, 32'hDEADBEEF);
    // SW 0x204 with same-cycle ack, then a bubble: no request must linger
    run_instr(1, 0, 0, 0, 1, 0, 0, 5'd0, 32'h204, 32'h12345678, 0, 32'hFFFF0000);
    run_instr(0, 0, 0, 0, 0, 0, 1, 5'd9, 32'h55, 32'h0, 0, 32'h0);
    // Branch taken / not taken
    run_instr(1, 1, 1, 0, 0, 0, 0, 5'd0, 32'h8, 32'h0, 0, 32'h0);
    run_instr(1, 1, 0, 0, 0, 0, 0, 5'd0, 32'h8, 32'h0, 0, 32'h0);
    // Misaligned load, then read+write both set
    run_instr(1, 0, 0, 1, 0, 1, 1, 5'd3, 32'h102, 32'h0, 0, 32'h0);
    run_instr(1, 0, 0, 1, 1, 0, 1, 5'd4, 32'h200, 32'h1, 0, 32'h0);
    // Timeout: never acked, followed by a bubble
    run_instr(1, 0, 0, 1, 0, 1, 1, 5'd6, 32'h40, 32'h0, 99, 32'h0);
    run_instr(0, 0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 32'h0);

    #2;
    apply_reset();

    for (int i = 0; i < 150; i++) begin
      r_v   = ($urandom_range(0, 7) != 0);
      kind  = $urandom_range(0, 3);
      r_mr  = (kind == 2);
      r_mw  = (kind == 3);
      r_alu = $urandom();
      if (kind >= 2) begin
        r_alu = r_alu & 32'hFFFF_FFFC;
        if ($urandom_range(0, 9) == 0) begin
          if ($urandom_range(0, 1) == 0) r_alu[1:0] = 2'($urandom_range(1, 3));
          else begin r_mr = 1'b1; r_mw = 1'b1; end
        end
      end
      r_br = 1'($urandom_range(0, 1));
      r_zr = 1'($urandom_range(0, 1));
      run_instr(r_v, r_br, r_zr, r_mr, r_mw, 1'($urandom_range(0, 1)),
                1'($urandom_range(0, 1)), 5'($urandom_range(0, 31)), r_alu,
                $urandom(), $urandom_range(0, 6), $urandom());
    end

    // Reset in the middle of WAIT with the request inputs still held
    validIN = 1; BranchIN = 0; zeroIN = 0; MemReadIN = 1; MemWriteIN = 0;
    MemtoRegIN = 1; RegWriteIN = 1; destinationRegisterIN = 5'd2;
    ALUResultIN = 32'h300; readData2IN = 32'h0; bus.memAck = 0;
    for (int c = 0; c < 3; c++) begin
      #1;
      chk("wait_memReq", bus.memReq, 1'b1);
      @(negedge clk);
    end
    #2;
    apply_reset();
    run_instr(0, 0, 0, 0, 0, 0, 0, 5'd0, 32'h0, 32'h0, 0, 32'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/mem_access_stage.md
MEM_ACCESS_STAGE -- requirements
Module: mem_access_stage

Interface
REQ-001 Parameter: TIMEOUT_CYC, 255, max cycles WAIT holds memReq without memAck before abort (1..255).
REQ-002 clk  in  1  single clock; all state updates on posedge clk.
REQ-003 rst_n  in  1  asynchronous, active-low reset.
REQ-004 validIN  in  1  EX/MEM slot holds a real instruction.
REQ-005 BranchIN, MemReadIN, MemtoRegIN, MemWriteIN, RegWriteIN, zeroIN  in  1 each  EX/MEM control and zero flag.
REQ-006 destinationRegisterIN  in  5  write-back register index.
REQ-007 ALUResultIN  in  32  memory byte address or ALU result.
REQ-008 readData2IN  in  32  store data.
REQ-009 memAck  in  1  memory completes request this cycle.
REQ-010 memRdata  in  32  load data, valid when memAck=1.
REQ-011 stall  out  1  combinational; EX/MEM and earlier stages hold while 1.
REQ-012 PCSrc  out  1  combinational; BranchIN & zeroIN & validIN.
REQ-013 memReq, memWe  out  1 each  request strobe; write enable.
REQ-014 memAddr, memWdata  out  32 each  request address; store data.
REQ-015 RegWriteOUT, MemtoRegOUT  out  1 each  MEM/WB controls.
REQ-016 destinationRegisterOUT  out  5  MEM/WB destination.
REQ-017 ALUResultOUT, readDataOUT  out  32 each  MEM/WB ALU result; load data.
REQ-018 memError  out  1  sticky fault flag.

Function
REQ-019 FSM states IDLE and WAIT only.
REQ-020 IDLE, validIN=0: next edge loads MEM/WB with bubble (RegWriteOUT=0, other MEM/WB outputs unchanged); stall=0.
REQ-021 IDLE, valid non-memory op (MemReadIN=MemWriteIN=0): next edge loads all MEM/WB outputs from inputs; latency 1; stall=0.
REQ-022 IDLE, valid memory op: memReq=1 same cycle, memAddr=ALUResultIN, memWdata=readData2IN, memWe=MemWriteIN; stall=1; next edge -> WAIT unless memAck=1 that cycle.
REQ-023 WAIT: memReq, memWe, memAddr, memWdata held from registered copies, stable until ack; stall=1; MEM/WB outputs unchanged.
REQ-024 Ack (IDLE same-cycle or WAIT): stall=0 that cycle; next edge -> IDLE, loads MEM/WB; readDataOUT=memRdata for loads, unchanged for stores.
REQ-025 Timeout counter clears on WAIT entry, increments each WAIT cycle without ack; count=TIMEOUT_CYC -> memError=1, memReq drops, bubble loaded, -> IDLE, stall=0.
REQ-026 MemReadIN=MemWriteIN=1, or ALUResultIN[1:0]!=0 on a memory op: no request, memError=1, bubble loaded, stall=0.
REQ-027 memAck outside an active request ignored; ack on timeout cycle counts as success.
REQ-028 memError clears only on reset.
REQ-029 PCSrc independent of FSM state; upstream holds inputs stable while stall=1.

Reset
REQ-030 rst_n low: FSM=IDLE, counter=0, memReq=0, memWe=0, memAddr=0, memWdata=0, all MEM/WB outputs 0, memError=0, effective immediately.
REQ-031 Reset mid-WAIT abandons request; memReq low at reset assertion; no MEM/WB load.
REQ-032 Release synchronous to clk; first active edge evaluates IDLE rules.

Structure
REQ-033 Package cpu_pkg: state enum {IDLE, WAIT}, word width 32, regIndex width 5.
REQ-034 One sub-module mem_wb_reg: MEM/WB register with load enable and bubble insert.

Verification
REQ-035 ADD to r5=0x0000_0010, validIN=1 -> next edge RegWriteOUT=1, destinationRegisterOUT=5, ALUResultOUT=0x10, stall never 1.
REQ-036 LW addr 0x100, memAck after 3 WAIT cycles, memRdata=0xDEADBEEF -> stall high 4 cycles, memAddr=0x100 stable, readDataOUT=0xDEADBEEF, MemtoRegOUT=1.
REQ-037 SW addr 0x204, data 0x12345678, same-cycle ack -> memWe=1, memWdata=0x12345678, stall 0, no WAIT entry.
REQ-038 LW addr 0x102 -> memReq never 1, memError=1, RegWriteOUT=0.
REQ-039 TIMEOUT_CYC=4, no ack -> memReq drops after 4 WAIT cycles, memError=1, stall=0; rst_n low mid-WAIT -> all outputs 0 immediately.
REQ-040 BranchIN=1, zeroIN=1, validIN=1 -> PCSrc=1 same cycle; zeroIN=0 -> PCSrc=0.
